// File: rtl/serial_frame_transmitter.sv
`default_nettype none
// ============================================================================
// serial_frame_transmitter : parallel word -> start/data/[parity]/stop frame
// Revision: 1.0
// ============================================================================
module serial_frame_transmitter #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 0,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  output logic                  Ready_Out,
  output logic                  Serial_Out,
  output logic                  Busy_Out,
  output logic                  Done_Out
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  ser_q, ser_d;
  logic                  done_q, done_d;

  logic                  last_w;
  logic                  next_bit_w;
  logic [DATA_WIDTH-1:0] shifted_w;

  assign last_w     = (cnt_q == CNT_LAST);
  assign next_bit_w = (MSB_FIRST != 0) ? shift_q[DATA_WIDTH-1] : shift_q[0];
  assign shifted_w  = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    ser_d   = ser_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = last_w ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        ser_d = 1'b1;
        if (Valid_In) begin
          // Parity is latched at capture since the shift register is consumed.
          shift_d = Data_In;
          par_d   = (^Data_In) ^ (PARITY_ODD != 0);
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
          ser_d   = 1'b0;
        end
      end
      S_START: begin
        if (last_w) begin
          state_d = S_DATA;
          ser_d   = next_bit_w;
          shift_d = shifted_w;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (last_w) begin
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              ser_d   = par_q;
            end else begin
              state_d = S_STOP;
              ser_d   = 1'b1;
            end
          end else begin
            ser_d   = next_bit_w;
            shift_d = shifted_w;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (last_w) begin
          state_d = S_STOP;
          ser_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (last_w) begin
          state_d = S_IDLE;
          ser_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ser_d   = 1'b1;
      end
    endcase
  end

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  assign Ready_Out  = (state_q == S_IDLE);
  assign Busy_Out   = (state_q != S_IDLE);
  assign Serial_Out = ser_q;
  assign Done_Out   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_transmitter.sv
`default_nettype none
// ============================================================================
// tb_serial_frame_transmitter : three configurations checked against a
// frame-level reference model. Revision: 1.0
// ============================================================================
module tb_serial_frame_transmitter;

  logic       clk;
  logic       rst;
  logic [7:0] data_r [3];
  logic       valid_r [3];
  logic       ser_o [3];
  logic       rdy_o [3];
  logic       busy_o [3];
  logic       done_o [3];

  int n_checks;
  int n_errors;
  bit chk_en;

  // Expected per-cycle {serial, busy, done} after each falling edge.
  logic [2:0] exp_tab [3][48];
  int         len [3];
  int         pos [3];
  logic [2:0] cur [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d0: defaults; d1: even parity; d2: MSB first, 4 clks/bit, odd parity
  serial_frame_transmitter u_d0 (
    .Clk_In(clk), .Reset_In(rst), .Data_In(data_r[0]), .Valid_In(valid_r[0]),
    .Ready_Out(rdy_o[0]), .Serial_Out(ser_o[0]), .Busy_Out(busy_o[0]), .Done_Out(done_o[0]));

  serial_frame_transmitter #(.PARITY_EN(1), .PARITY_ODD(0)) u_d1 (
    .Clk_In(clk), .Reset_In(rst), .Data_In(data_r[1]), .Valid_In(valid_r[1]),
    .Ready_Out(rdy_o[1]), .Serial_Out(ser_o[1]), .Busy_Out(busy_o[1]), .Done_Out(done_o[1]));

  serial_frame_transmitter #(.CLKS_PER_BIT(4), .MSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1)) u_d2 (
    .Clk_In(clk), .Reset_In(rst), .Data_In(data_r[2]), .Valid_In(valid_r[2]),
    .Ready_Out(rdy_o[2]), .Serial_Out(ser_o[2]), .Busy_Out(busy_o[2]), .Done_Out(done_o[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame = start, 8 data bits in line order, optional parity, stop;
  // each bit repeated for its bit time, then one idle cycle with done.
  task automatic build(input int id, input logic [7:0] d);
    logic b [$];
    int   cpb;
    cpb = (id == 2) ? 4 : 1;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back((id == 2) ? d[7-i] : d[i]);
    if (id != 0) b.push_back((^d) ^ (id == 2));
    b.push_back(1'b1);
    len[id] = 0;
    pos[id] = 0;
    foreach (b[k]) begin
      for (int r = 0; r < cpb; r++) begin
        exp_tab[id][len[id]] = {b[k], 1'b1, 1'b0};
        len[id]++;
      end
    end
    exp_tab[id][len[id]] = 3'b101;
    len[id]++;
  endtask

  always @(negedge clk or posedge rst) begin
    for (int id = 0; id < 3; id++) begin
      if (rst) begin
        len[id] = 0;
        pos[id] = 0;
        cur[id] = 3'b100;
      end else begin
        if (pos[id] >= len[id] && valid_r[id]) build(id, data_r[id]);
        if (pos[id] < len[id]) begin
          cur[id] = exp_tab[id][pos[id]];
          pos[id]++;
        end else begin
          cur[id] = 3'b100;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      for (int id = 0; id < 3; id++) begin
        chk($sformatf("d%0d.serial", id), 32'(ser_o[id]),  32'(cur[id][2]));
        chk($sformatf("d%0d.busy", id),   32'(busy_o[id]), 32'(cur[id][1]));
        chk($sformatf("d%0d.done", id),   32'(done_o[id]), 32'(cur[id][0]));
        chk($sformatf("d%0d.ready", id),  32'(rdy_o[id]),  32'(!cur[id][1]));
      end
    end
  end

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((busy_o[id] || pos[id] < len[id]) && n < 200);
    if (n >= 200) chk($sformatf("d%0d.timeout", id), 32'd0, 32'd1);
    @(posedge clk);
  endtask

  // Pulse Valid_In for one edge, then scramble Data_In while the frame runs.
  task automatic send(input int id, input logic [7:0] d);
    @(posedge clk);
    data_r[id]  = d;
    valid_r[id] = 1'b1;
    @(posedge clk);
    valid_r[id] = 1'b0;
    data_r[id]  = ~d;
    wait_idle(id);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_r[i]  = 8'h00;
      valid_r[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);

    send(0, 8'hA5);
    send(1, 8'h07);
    send(2, 8'h07);
    send(2, 8'h80);

    // Valid held high across two frames; data changes mid-frame 1.
    @(posedge clk);
    data_r[0]  = 8'h00;
    valid_r[0] = 1'b1;
    repeat (4) @(posedge clk);
    data_r[0] = 8'hFF;
    repeat (12) @(posedge clk);
    valid_r[0] = 1'b0;
    wait_idle(0);

    // Valid pulsed while busy must be ignored.
    @(posedge clk);
    data_r[1]  = 8'h3A;
    valid_r[1] = 1'b1;
    @(posedge clk);
    valid_r[1] = 1'b0;
    repeat (3) @(posedge clk);
    data_r[1]  = 8'h55;
    valid_r[1] = 1'b1;
    @(posedge clk);
    valid_r[1] = 1'b0;
    wait_idle(1);
    repeat (4) @(posedge clk);

    // Asynchronous reset during data bit 3.
    @(posedge clk);
    data_r[0]  = 8'h5A;
    valid_r[0] = 1'b1;
    @(posedge clk);
    valid_r[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst.serial", 32'(ser_o[0]), 32'd1);
    chk("rst.busy",   32'(busy_o[0]), 32'd0);
    chk("rst.ready",  32'(rdy_o[0]), 32'd1);
    chk("rst.done",   32'(done_o[0]), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    send(0, 8'h3C);

    for (int rep = 0; rep < 6; rep++) begin
      for (int id = 0; id < 3; id++) begin
        send(id, 8'($urandom));
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_frame_transmitter.md
Name: serial_frame_transmitter

Overview:
Converts a parallel data word into a framed serial bit stream: start bit, data bits, optional parity bit, stop bit. It is the transmit end of the team's serial link. It is built from the same falling-edge, asynchronously reset storage the flip-flop library provides. It sits between a parallel producer (valid/ready handshake) and a single-wire serial line.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (1..32)
CLKS_PER_BIT, 1, clock cycles each serial bit is held (>=1)
MSB_FIRST, 0, 1 = send data MSB first, 0 = send LSB first
PARITY_EN, 0, 1 = insert parity bit after the data bits
PARITY_ODD, 0, parity sense when enabled: 0 = even, 1 = odd

Ports:
Clk_In  input  1  clock; all state updates on the falling edge
Reset_In  input  1  asynchronous, active-high reset
Data_In  input  DATA_WIDTH  parallel word to send
Valid_In  input  1  producer has a word on Data_In
Ready_Out  output  1  transmitter can accept a word (high only in IDLE)
Serial_Out  output  1  serial line, registered, idles high
Busy_Out  output  1  high while a frame is in progress (any state other than IDLE)
Done_Out  output  1  one-cycle pulse marking the end of the stop bit

Behaviour:
- Clocking and reset: one clock, Clk_In; all registers update on the falling edge of Clk_In. Reset_In is asynchronous and active-high.
- Reset values: state=IDLE, Serial_Out=1, Done_Out=0, Busy_Out=0, Ready_Out=1, bit counter and cycle counter=0, shift register=0.
- Outputs: Ready_Out = (state==IDLE) and Busy_Out = (state!=IDLE); both are decoded from registered state. Serial_Out and Done_Out are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Serial_Out=1.
  - A falling edge with Valid_In=1 accepts the word: Data_In is captured into the shift register, state goes to START and Serial_Out=0 on that same edge.
  - Valid_In=0: state stays IDLE.
- Bit timing: each state holds its bit for exactly CLKS_PER_BIT cycles, counted by a cycle counter. Transitions happen on the edge where the counter reaches CLKS_PER_BIT-1; the counter then clears.
- START -> DATA. Serial_Out takes the first data bit: bit 0 if MSB_FIRST=0, bit DATA_WIDTH-1 if MSB_FIRST=1.
- DATA:
  - Sends DATA_WIDTH bits in order, shifting once per bit period.
  - After the last bit, goes to PARITY if PARITY_EN=1, else to STOP.
- PARITY:
  - Serial_Out = XOR of the captured word, inverted when PARITY_ODD=1. The captured word is held separately, or parity is precomputed at capture.
  - Goes to STOP.
- STOP: Serial_Out=1. At the end of the period: state goes to IDLE, Done_Out=1 for exactly one cycle, Ready_Out rises.
- Frame length: (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles, from the accept edge to the edge that raises Done_Out.
- Back-to-back frames: if Valid_In is held high, the next word is accepted on the edge after the IDLE cycle. The line is therefore high for exactly 1 clock between frames, and that cycle is the one in which Done_Out=1.
- Data_In and Valid_In are ignored outside IDLE. There is no queuing, and data changes after capture have no effect on the frame in flight.
- Reset asserted mid-frame: Serial_Out goes to 1 immediately (asynchronously), state goes to IDLE, the frame is abandoned and no Done_Out pulse is produced. After release, the block behaves exactly as after power-up reset.
- Reset asserted on the same edge as an accept: reset wins and nothing is captured.

Test Plan:
- Defaults (width 8, 1 clk/bit, LSB first, no parity); Data_In=0xA5, Valid_In pulsed for one edge -> Serial_Out over 10 edges = 0,1,0,1,0,0,1,0,1,1; Done_Out high for 1 cycle at edge 10; Busy_Out high for edges 1-10; Ready_Out low for edges 1-10.
- PARITY_EN=1, PARITY_ODD=0, Data_In=0x07 -> parity bit 1, 11-cycle frame. Repeat with PARITY_ODD=1 -> parity bit 0.
- MSB_FIRST=1, Data_In=0x80 -> first data bit 1, then seven 0s. CLKS_PER_BIT=4 -> every bit held exactly 4 cycles; total frame 40 cycles.
- Valid_In held high with 0x00 then 0xFF -> frame 1 completes; exactly one high idle cycle, with Done_Out=1; frame 2 starts on the next edge. Data_In changed mid-frame -> frame 1 bits unchanged.
- Reset_In asserted between clock edges during data bit 3 -> Serial_Out=1, Busy_Out=0, Ready_Out=1 immediately; no Done_Out pulse. A new 0x3C frame after release is sent correctly.
- Valid_In pulsed while Busy_Out=1 -> ignored; no extra frame is sent after the current frame completes.
